// File: rtl/sobel_gcd_cmd_sched.sv
// Command scheduler between the SPI deserializer and the Sobel / GCD engines.
// Each 16-bit host word is {opcode, data}. The block configures the engines,
// starts them, and owns the single response path back to the SPI TX register.
// While an engine operation is in flight, new words are dropped and counted.
module sobel_gcd_cmd_sched #(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int DROP_CNT_W     = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid_i,
  input  logic [15:0] cmd_data_i,
  output logic        cmd_ready_o,
  output logic [15:0] rsp_data_o,
  output logic        rsp_load_o,
  output logic        engine_sel_o,
  output logic [7:0]  gcd_a_o,
  output logic [7:0]  gcd_b_o,
  output logic        gcd_start_o,
  input  logic        gcd_done_i,
  input  logic [7:0]  gcd_result_i,
  output logic [7:0]  sobel_pix_o,
  output logic        sobel_pix_valid_o,
  input  logic        sobel_pix_ready_i,
  input  logic        sobel_out_valid_i,
  input  logic [7:0]  sobel_out_i
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [7:0] OP_CTRL   = 8'h00;
  localparam logic [7:0] OP_SET_A  = 8'h01;
  localparam logic [7:0] OP_SET_B  = 8'h02;
  localparam logic [7:0] OP_GCD_GO = 8'h03;
  localparam logic [7:0] OP_PIX    = 8'h10;
  localparam logic [7:0] OP_READ   = 8'h11;
  localparam logic [7:0] OP_STATUS = 8'h20;
  localparam logic [7:0] RSP_ERR   = 8'hEE;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_GCD_RUN    = 2'd1,
    ST_SOBEL_PUSH = 2'd2
  } state_t;

  state_t                r_state, w_state_nxt;
  logic                  r_alive;
  logic                  r_sel, w_sel_nxt;
  logic [7:0]            r_gcd_a, w_gcd_a_nxt;
  logic [7:0]            r_gcd_b, w_gcd_b_nxt;
  logic                  r_gcd_start, w_gcd_start_nxt;
  logic [7:0]            r_pix, w_pix_nxt;
  logic [15:0]           r_rsp_data, w_rsp_data_nxt;
  logic                  r_rsp_load, w_rsp_load_nxt;
  logic [DROP_CNT_W-1:0] r_drop, w_drop_nxt;
  logic                  r_ovf, w_ovf_nxt;
  logic                  r_err, w_err_nxt;
  logic [7:0]            r_hold, w_hold_nxt;
  logic                  r_hold_valid, w_hold_valid_nxt;
  logic [TMO_W-1:0]      r_tmo, w_tmo_nxt;

  logic                  w_accept;
  logic [7:0]            w_op;
  logic [7:0]            w_d;
  logic                  w_hold_clr;
  logic                  w_fail;
  logic [7:0]            w_fail_op;
  logic                  w_tmo_hit;
  logic [3:0]            w_drop4;

  // Saturating increment for the dropped-command counter.
  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (&v) ? v : v + DROP_CNT_W'(1);
  endfunction

  assign w_accept  = cmd_valid_i && cmd_ready_o;
  assign w_op      = cmd_data_i[15:8];
  assign w_d       = cmd_data_i[7:0];
  assign w_tmo_hit = (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1));
  assign w_drop4   = 4'(r_drop);

  assign cmd_ready_o       = r_alive && (r_state == ST_IDLE);
  assign rsp_data_o        = r_rsp_data;
  assign rsp_load_o        = r_rsp_load;
  assign engine_sel_o      = r_sel;
  assign gcd_a_o           = r_gcd_a;
  assign gcd_b_o           = r_gcd_b;
  assign gcd_start_o       = r_gcd_start;
  assign sobel_pix_o       = r_pix;
  assign sobel_pix_valid_o = (r_state == ST_SOBEL_PUSH);

  // FSM state register; ready is held off until the first clock after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_alive <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_alive <= 1'b1;
    end
  end

  // Command decode, engine sequencing, timeout, drop accounting and Sobel capture.
  always_comb begin
    w_state_nxt      = r_state;
    w_sel_nxt        = r_sel;
    w_gcd_a_nxt      = r_gcd_a;
    w_gcd_b_nxt      = r_gcd_b;
    w_gcd_start_nxt  = 1'b0;
    w_pix_nxt        = r_pix;
    w_rsp_data_nxt   = r_rsp_data;
    w_rsp_load_nxt   = 1'b0;
    w_drop_nxt       = r_drop;
    w_ovf_nxt        = r_ovf;
    w_err_nxt        = r_err;
    w_hold_nxt       = r_hold;
    w_hold_valid_nxt = r_hold_valid;
    w_tmo_nxt        = r_tmo;
    w_hold_clr       = 1'b0;
    w_fail           = 1'b0;
    w_fail_op        = w_op;

    if (cmd_valid_i && !cmd_ready_o) begin
      w_drop_nxt = sat_inc(r_drop);
      w_ovf_nxt  = 1'b1;
    end

    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          case (w_op)
            OP_CTRL: begin
              w_sel_nxt = w_d[0];
              if (w_d[7]) begin
                w_drop_nxt = '0;
                w_ovf_nxt  = 1'b0;
                w_err_nxt  = 1'b0;
                w_hold_clr = 1'b1;
              end
            end
            OP_SET_A: w_gcd_a_nxt = w_d;
            OP_SET_B: w_gcd_b_nxt = w_d;
            OP_GCD_GO: begin
              if (r_sel) begin
                w_gcd_start_nxt = 1'b1;
                w_state_nxt     = ST_GCD_RUN;
                w_tmo_nxt       = '0;
              end else begin
                w_fail = 1'b1;
              end
            end
            OP_PIX: begin
              if (!r_sel) begin
                w_pix_nxt   = w_d;
                w_state_nxt = ST_SOBEL_PUSH;
                w_tmo_nxt   = '0;
              end else begin
                w_fail = 1'b1;
              end
            end
            OP_READ: begin
              if (r_hold_valid) begin
                w_rsp_data_nxt = {OP_READ, r_hold};
                w_rsp_load_nxt = 1'b1;
                w_hold_clr     = 1'b1;
              end else begin
                w_fail = 1'b1;
              end
            end
            OP_STATUS: begin
              w_rsp_data_nxt = {OP_STATUS, r_ovf, r_err, r_hold_valid, r_sel, w_drop4};
              w_rsp_load_nxt = 1'b1;
            end
            default: w_fail = 1'b1;
          endcase
        end
      end
      ST_GCD_RUN: begin
        // A completion landing in the timeout cycle still counts as success.
        if (gcd_done_i) begin
          w_rsp_data_nxt = {OP_GCD_GO, gcd_result_i};
          w_rsp_load_nxt = 1'b1;
          w_state_nxt    = ST_IDLE;
        end else if (w_tmo_hit) begin
          w_fail      = 1'b1;
          w_fail_op   = OP_GCD_GO;
          w_state_nxt = ST_IDLE;
        end else begin
          w_tmo_nxt = r_tmo + TMO_W'(1);
        end
      end
      ST_SOBEL_PUSH: begin
        if (sobel_pix_ready_i) begin
          w_state_nxt = ST_IDLE;
        end else if (w_tmo_hit) begin
          w_fail      = 1'b1;
          w_fail_op   = OP_PIX;
          w_state_nxt = ST_IDLE;
        end else begin
          w_tmo_nxt = r_tmo + TMO_W'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    if (w_fail) begin
      w_rsp_data_nxt = {RSP_ERR, w_fail_op};
      w_rsp_load_nxt = 1'b1;
      w_err_nxt      = 1'b1;
    end

    // A Sobel result arriving while the holding register is being cleared
    // replaces it; the READ response already carries the old value.
    if (w_hold_clr) begin
      w_hold_valid_nxt = 1'b0;
    end
    if (sobel_out_valid_i) begin
      if (!r_hold_valid || w_hold_clr) begin
        w_hold_nxt       = sobel_out_i;
        w_hold_valid_nxt = 1'b1;
      end else begin
        w_ovf_nxt = 1'b1;
      end
    end
  end

  // Operand, response, status and capture registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel        <= 1'b0;
      r_gcd_a      <= '0;
      r_gcd_b      <= '0;
      r_gcd_start  <= 1'b0;
      r_pix        <= '0;
      r_rsp_data   <= '0;
      r_rsp_load   <= 1'b0;
      r_drop       <= '0;
      r_ovf        <= 1'b0;
      r_err        <= 1'b0;
      r_hold       <= '0;
      r_hold_valid <= 1'b0;
      r_tmo        <= '0;
    end else begin
      r_sel        <= w_sel_nxt;
      r_gcd_a      <= w_gcd_a_nxt;
      r_gcd_b      <= w_gcd_b_nxt;
      r_gcd_start  <= w_gcd_start_nxt;
      r_pix        <= w_pix_nxt;
      r_rsp_data   <= w_rsp_data_nxt;
      r_rsp_load   <= w_rsp_load_nxt;
      r_drop       <= w_drop_nxt;
      r_ovf        <= w_ovf_nxt;
      r_err        <= w_err_nxt;
      r_hold       <= w_hold_nxt;
      r_hold_valid <= w_hold_valid_nxt;
      r_tmo        <= w_tmo_nxt;
    end
  end

endmodule

// File: tb/tb_sobel_gcd_cmd_sched.sv
// Bench for sobel_gcd_cmd_sched: directed command sequences, a behavioural
// scheduler model compared every cycle, and literal response expectations.
module tb_sobel_gcd_cmd_sched;

  localparam int TMO  = 4096;
  localparam int DW   = 4;
  localparam int DMAX = (1 << DW) - 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid_i = 1'b0;
  logic [15:0] cmd_data_i = '0;
  logic        cmd_ready_o;
  logic [15:0] rsp_data_o;
  logic        rsp_load_o;
  logic        engine_sel_o;
  logic [7:0]  gcd_a_o, gcd_b_o;
  logic        gcd_start_o;
  logic        gcd_done_i = 1'b0;
  logic [7:0]  gcd_result_i = '0;
  logic [7:0]  sobel_pix_o;
  logic        sobel_pix_valid_o;
  logic        sobel_pix_ready_i = 1'b0;
  logic        sobel_out_valid_i = 1'b0;
  logic [7:0]  sobel_out_i = '0;

  int n_chk = 0;
  int n_pass = 0;

  sobel_gcd_cmd_sched #(.TIMEOUT_CYCLES(TMO), .DROP_CNT_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid_i(cmd_valid_i), .cmd_data_i(cmd_data_i), .cmd_ready_o(cmd_ready_o),
    .rsp_data_o(rsp_data_o), .rsp_load_o(rsp_load_o), .engine_sel_o(engine_sel_o),
    .gcd_a_o(gcd_a_o), .gcd_b_o(gcd_b_o), .gcd_start_o(gcd_start_o),
    .gcd_done_i(gcd_done_i), .gcd_result_i(gcd_result_i),
    .sobel_pix_o(sobel_pix_o), .sobel_pix_valid_o(sobel_pix_valid_o),
    .sobel_pix_ready_i(sobel_pix_ready_i),
    .sobel_out_valid_i(sobel_out_valid_i), .sobel_out_i(sobel_out_i)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
  endfunction

  // ---------------- behavioural model ----------------
  int         m_mode;   // 0 idle, 1 waiting for GCD, 2 offering a pixel
  int         m_wait;
  int         m_drops;
  bit         m_alive, m_ready, m_sel, m_ovf, m_err, m_holdv, e_start, e_load;
  logic [7:0] m_a, m_b, m_pix, m_hold, t_op, t_d;
  logic [15:0] e_rsp;
  bit         t_clr;

  function automatic void m_reset();
    m_mode = 0; m_wait = 0; m_drops = 0;
    m_alive = 0; m_ready = 0; m_sel = 0; m_ovf = 0; m_err = 0; m_holdv = 0;
    e_start = 0; e_load = 0; e_rsp = '0;
    m_a = '0; m_b = '0; m_pix = '0; m_hold = '0;
  endfunction

  function automatic void m_respond(input logic [15:0] v);
    e_load = 1; e_rsp = v;
  endfunction

  function automatic void m_fail(input logic [7:0] op);
    m_respond({8'hEE, op});
    m_err = 1;
  endfunction

  initial m_reset();

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_reset();
    end else begin
      e_start = 0; e_load = 0; t_clr = 0;
      t_op = cmd_data_i[15:8];
      t_d  = cmd_data_i[7:0];
      if (cmd_valid_i && !m_ready) begin
        m_drops = (m_drops < DMAX) ? m_drops + 1 : DMAX;
        m_ovf   = 1;
      end
      if (cmd_valid_i && m_ready) begin
        if (t_op == 8'h00) begin
          m_sel = t_d[0];
          if (t_d[7]) begin m_drops = 0; m_ovf = 0; m_err = 0; t_clr = 1; end
        end else if (t_op == 8'h01) m_a = t_d;
        else if (t_op == 8'h02) m_b = t_d;
        else if (t_op == 8'h03) begin
          if (m_sel) begin e_start = 1; m_mode = 1; m_wait = 0; end
          else m_fail(t_op);
        end else if (t_op == 8'h10) begin
          if (!m_sel) begin m_pix = t_d; m_mode = 2; m_wait = 0; end
          else m_fail(t_op);
        end else if (t_op == 8'h11) begin
          if (m_holdv) begin m_respond({8'h11, m_hold}); t_clr = 1; end
          else m_fail(t_op);
        end else if (t_op == 8'h20) begin
          m_respond({8'h20, m_ovf, m_err, m_holdv, m_sel, 4'(m_drops)});
        end else m_fail(t_op);
      end else if (m_mode == 1) begin
        m_wait++;
        if (gcd_done_i) begin m_respond({8'h03, gcd_result_i}); m_mode = 0; end
        else if (m_wait >= TMO) begin m_fail(8'h03); m_mode = 0; end
      end else if (m_mode == 2) begin
        m_wait++;
        if (sobel_pix_ready_i) m_mode = 0;
        else if (m_wait >= TMO) begin m_fail(8'h10); m_mode = 0; end
      end
      if (t_clr) m_holdv = 0;
      if (sobel_out_valid_i) begin
        if (!m_holdv) begin m_hold = sobel_out_i; m_holdv = 1; end
        else m_ovf = 1;
      end
      m_alive = 1;
      m_ready = (m_mode == 0);
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("c_ready", 32'(cmd_ready_o), 32'(m_ready));
    chk("c_load", 32'(rsp_load_o), 32'(e_load));
    if (e_load) chk("c_rsp", 32'(rsp_data_o), 32'(e_rsp));
    chk("c_start", 32'(gcd_start_o), 32'(e_start));
    chk("c_pixv", 32'(sobel_pix_valid_o), 32'(m_mode == 2));
    if (m_mode == 2) chk("c_pix", 32'(sobel_pix_o), 32'(m_pix));
    chk("c_sel", 32'(engine_sel_o), 32'(m_sel));
    chk("c_a", 32'(gcd_a_o), 32'(m_a));
    chk("c_b", 32'(gcd_b_o), 32'(m_b));
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [15:0] w);
    int n = 0;
    while (!cmd_ready_o && n < 200) begin tick(); n++; end
    if (!cmd_ready_o) chk("send_ready", 32'(cmd_ready_o), 32'd1);
    cmd_valid_i = 1'b1; cmd_data_i = w;
    tick();
    cmd_valid_i = 1'b0;
  endtask

  task automatic expect_rsp(input logic [15:0] exp, input string nm, input int budget);
    int n = 0;
    while (!rsp_load_o && n < budget) begin tick(); n++; end
    chk({nm, "_load"}, 32'(rsp_load_o), 32'd1);
    chk(nm, 32'(rsp_data_o), 32'(exp));
  endtask

  task automatic sobel_out(input logic [7:0] v);
    sobel_out_valid_i = 1'b1; sobel_out_i = v;
    tick();
    sobel_out_valid_i = 1'b0;
  endtask

  initial begin
    int cnt;
    int n;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(cmd_ready_o), 32'd0);
    chk("rst_rsp", 32'(rsp_data_o), 32'd0);
    chk("rst_load", 32'(rsp_load_o), 32'd0);
    rst_n = 1'b1;
    chk("ready_at_release", 32'(cmd_ready_o), 32'd0);
    tick();
    chk("ready_rise", 32'(cmd_ready_o), 32'd1);

    // Errors while Sobel owns the path
    send(16'h0300); expect_rsp(16'hEE03, "go_sel0", 2);
    send(16'h2000); expect_rsp(16'h2040, "status_err", 2);
    send(16'h5533); expect_rsp(16'hEE55, "bad_op", 2);
    send(16'h0080);

    // Pixel held under backpressure
    sobel_pix_ready_i = 1'b0;
    send(16'h10A5);
    cnt = 0;
    repeat (5) begin
      if (sobel_pix_valid_o && sobel_pix_o == 8'hA5) cnt++;
      tick();
    end
    sobel_pix_ready_i = 1'b1;
    if (sobel_pix_valid_o && sobel_pix_o == 8'hA5) cnt++;
    tick();
    sobel_pix_ready_i = 1'b0;
    chk("pix_hold_cycles", 32'(cnt), 32'd6);
    chk("pix_valid_drop", 32'(sobel_pix_valid_o), 32'd0);

    // Sobel capture and readback
    sobel_out(8'h7F);
    send(16'h1100); expect_rsp(16'h117F, "read_hold", 2);
    send(16'h1100); expect_rsp(16'hEE11, "read_empty", 2);
    sobel_out(8'h11);
    cmd_valid_i = 1'b1; cmd_data_i = 16'h1100;
    sobel_out_valid_i = 1'b1; sobel_out_i = 8'h22;
    tick();
    cmd_valid_i = 1'b0; sobel_out_valid_i = 1'b0;
    expect_rsp(16'h1111, "read_vs_capture", 2);
    send(16'h1100); expect_rsp(16'h1122, "read_new_capture", 2);
    send(16'h0080);

    // GCD run with drops while busy
    send(16'h0001); send(16'h0130); send(16'h0212); send(16'h0300);
    chk("gcd_start", 32'(gcd_start_o), 32'd1);
    chk("gcd_a", 32'(gcd_a_o), 32'h30);
    chk("gcd_b", 32'(gcd_b_o), 32'h12);
    repeat (3) tick();
    for (int i = 0; i < 3; i++) begin
      cmd_valid_i = 1'b1; cmd_data_i = 16'h2000;
      tick();
      cmd_valid_i = 1'b0;
      tick();
    end
    repeat (10) tick();
    chk("gcd_busy_ready", 32'(cmd_ready_o), 32'd0);
    gcd_done_i = 1'b1; gcd_result_i = 8'h06;
    tick();
    gcd_done_i = 1'b0;
    expect_rsp(16'h0306, "gcd_result", 1);
    send(16'h2000); expect_rsp(16'h2093, "status_drops", 2);
    send(16'h0081);
    send(16'h2000); expect_rsp(16'h2010, "status_cleared", 2);

    // Timeout with saturating drops
    send(16'h0300);
    n = 0;
    while (!rsp_load_o && n < TMO + 20) begin
      cmd_valid_i = (n >= 10 && n < 27);
      cmd_data_i = 16'h2000;
      tick();
      n++;
    end
    cmd_valid_i = 1'b0;
    chk("tmo_latency", 32'(n), 32'(TMO));
    expect_rsp(16'hEE03, "tmo_rsp", 1);
    send(16'h2000); expect_rsp(16'h20DF, "status_sat", 2);
    send(16'h0081);

    // Done arriving in the timeout cycle
    send(16'h0300);
    repeat (TMO - 1) tick();
    gcd_done_i = 1'b1; gcd_result_i = 8'h2A;
    tick();
    gcd_done_i = 1'b0;
    expect_rsp(16'h032A, "done_at_tmo", 1);
    send(16'h2000); expect_rsp(16'h2010, "status_after_done", 2);

    // Reset during a pixel push
    send(16'h0000);
    send(16'h105A);
    repeat (2) tick();
    rst_n = 1'b0;
    #1;
    chk("rst_pixv", 32'(sobel_pix_valid_o), 32'd0);
    chk("rst_pix", 32'(sobel_pix_o), 32'd0);
    chk("rst_load_mid", 32'(rsp_load_o), 32'd0);
    chk("rst_ready_mid", 32'(cmd_ready_o), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    send(16'h2000); expect_rsp(16'h2000, "status_post_rst", 2);

    repeat (3) tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

endmodule
